// File: rtl/ahb_ram_arbiter.sv
// ahb_ram_arbiter: shares one AHB-Lite RAM slave between two AHB-Lite masters, reissuing each registered request as a NONSEQ
module ahb_ram_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL_M0,
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [31:0] HWDATA_M0,
    input  logic        HREADY_M0,
    output logic        HREADYOUT_M0,
    output logic [31:0] HRDATA_M0,
    input  logic        HSEL_M1,
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [31:0] HWDATA_M1,
    input  logic        HREADY_M1,
    output logic        HREADYOUT_M1,
    output logic [31:0] HRDATA_M1,
    output logic        HSEL_S,
    output logic [31:0] HADDR_S,
    output logic [1:0]  HTRANS_S,
    output logic        HWRITE_S,
    output logic [2:0]  HSIZE_S,
    output logic [31:0] HWDATA_S,
    output logic        HREADY_S,
    input  logic        HREADYOUT_S,
    input  logic [31:0] HRDATA_S
);
    typedef enum logic [1:0] {IDLE, PEND, DATA} st_t;

    st_t         st_q [2];
    st_t         st_d [2];
    logic [31:0] addr_q [2];
    logic [31:0] addr_d [2];
    logic [31:0] haddr [2];
    logic        wr_q [2];
    logic        wr_d [2];
    logic        hwrite [2];
    logic [2:0]  size_q [2];
    logic [2:0]  size_d [2];
    logic [2:0]  hsize [2];
    logic [1:0]  req, acc, cand, gnt;
    logic        owner_valid_q, owner_valid_d;
    logic        owner_id_q, owner_id_d;
    logic        last_q, last_d;
    logic        gnt_valid, gnt_id;

    assign haddr[0]  = HADDR_M0;
    assign haddr[1]  = HADDR_M1;
    assign hwrite[0] = HWRITE_M0;
    assign hwrite[1] = HWRITE_M1;
    assign hsize[0]  = HSIZE_M0;
    assign hsize[1]  = HSIZE_M1;
    assign req = {HSEL_M1 && HREADY_M1 && (HTRANS_M1 inside {2'b10, 2'b11}),
                  HSEL_M0 && HREADY_M0 && (HTRANS_M0 inside {2'b10, 2'b11})};

    assign HREADYOUT_M0 = st_q[0] == IDLE || (st_q[0] == DATA && HREADYOUT_S);
    assign HREADYOUT_M1 = st_q[1] == IDLE || (st_q[1] == DATA && HREADYOUT_S);
    assign HRDATA_M0    = (owner_valid_q && !owner_id_q) ? HRDATA_S : '0;
    assign HRDATA_M1    = (owner_valid_q && owner_id_q) ? HRDATA_S : '0;
    assign HWDATA_S     = !owner_valid_q ? '0 : owner_id_q ? HWDATA_M1 : HWDATA_M0;

    always_comb begin
        HREADY_S  = owner_valid_q ? HREADYOUT_S : 1'b1;
        cand      = {st_q[1] == PEND, st_q[0] == PEND};
        gnt_valid = HREADY_S && |cand;
        // a tie goes to the master not granted last unless priority is fixed
        gnt_id    = &cand ? (ROUND_ROBIN != 0 ? ~last_q : 1'b0) : cand[1];
        gnt       = gnt_valid ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        HSEL_S    = gnt_valid;
        HTRANS_S  = gnt_valid ? 2'b10 : 2'b00;
        HADDR_S   = gnt_valid ? addr_q[gnt_id] : '0;
        HWRITE_S  = gnt_valid && wr_q[gnt_id];
        HSIZE_S   = gnt_valid ? size_q[gnt_id] : '0;
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < 2; i++) begin
            st_d[i]   = st_q[i];
            addr_d[i] = addr_q[i];
            wr_d[i]   = wr_q[i];
            size_d[i] = size_q[i];
            acc[i]    = req[i] && (st_q[i] == IDLE || (st_q[i] == DATA && HREADYOUT_S));
            if (acc[i]) begin
                st_d[i]   = PEND;
                addr_d[i] = haddr[i];
                wr_d[i]   = hwrite[i];
                size_d[i] = hsize[i];
            end else if (gnt[i])
                st_d[i] = DATA;
            else if (st_q[i] == DATA && HREADYOUT_S)
                st_d[i] = IDLE;
        end
        owner_valid_d = gnt_valid || (owner_valid_q && !HREADYOUT_S);
        owner_id_d    = gnt_valid ? gnt_id : owner_id_q;
        last_d        = gnt_valid ? gnt_id : last_q;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= IDLE;
                addr_q[i] <= '0;
                wr_q[i]   <= 1'b0;
                size_q[i] <= '0;
            end
            owner_valid_q <= 1'b0;
            owner_id_q    <= 1'b0;
            last_q        <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= st_d[i];
                addr_q[i] <= addr_d[i];
                wr_q[i]   <= wr_d[i];
                size_q[i] <= size_d[i];
            end
            owner_valid_q <= owner_valid_d;
            owner_id_q    <= owner_id_d;
            last_q        <= last_d;
        end
    end
endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// tb_ahb_ram_arbiter: directed bench with a RAM slave model on the round-robin instance and a fixed-priority twin
module tb_ahb_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        hsel0 = 0, hsel1 = 0, hwrite0 = 0, hwrite1 = 0;
    logic [31:0] haddr0 = 0, haddr1 = 0, hwdata0 = 0, hwdata1 = 0;
    logic [1:0]  htrans0 = 0, htrans1 = 0;
    logic [2:0]  hsize0 = 0, hsize1 = 0;
    logic        rdy0, rdy1, sel_s, write_s, hready_s;
    logic [31:0] rdata0, rdata1, addr_s, wdata_s, rdata_s;
    logic [1:0]  trans_s;
    logic [2:0]  size_s;
    logic        readyout_s = 1'b1;
    logic        f_rdy0, f_rdy1, f_sel_s, f_write_s, f_hready_s;
    logic [31:0] f_rdata0, f_rdata1, f_addr_s, f_wdata_s;
    logic [1:0]  f_trans_s;
    logic [2:0]  f_size_s;
    int errors = 0, checks = 0;

    ahb_ram_arbiter #(.ROUND_ROBIN(1)) u_dut (
        .HCLK(clk), .HRESET(rst),
        .HSEL_M0(hsel0), .HADDR_M0(haddr0), .HTRANS_M0(htrans0), .HWRITE_M0(hwrite0), .HSIZE_M0(hsize0),
        .HWDATA_M0(hwdata0), .HREADY_M0(rdy0), .HREADYOUT_M0(rdy0), .HRDATA_M0(rdata0),
        .HSEL_M1(hsel1), .HADDR_M1(haddr1), .HTRANS_M1(htrans1), .HWRITE_M1(hwrite1), .HSIZE_M1(hsize1),
        .HWDATA_M1(hwdata1), .HREADY_M1(rdy1), .HREADYOUT_M1(rdy1), .HRDATA_M1(rdata1),
        .HSEL_S(sel_s), .HADDR_S(addr_s), .HTRANS_S(trans_s), .HWRITE_S(write_s), .HSIZE_S(size_s),
        .HWDATA_S(wdata_s), .HREADY_S(hready_s), .HREADYOUT_S(readyout_s), .HRDATA_S(rdata_s)
    );

    ahb_ram_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .HCLK(clk), .HRESET(rst),
        .HSEL_M0(hsel0), .HADDR_M0(haddr0), .HTRANS_M0(htrans0), .HWRITE_M0(hwrite0), .HSIZE_M0(hsize0),
        .HWDATA_M0(hwdata0), .HREADY_M0(f_rdy0), .HREADYOUT_M0(f_rdy0), .HRDATA_M0(f_rdata0),
        .HSEL_M1(hsel1), .HADDR_M1(haddr1), .HTRANS_M1(htrans1), .HWRITE_M1(hwrite1), .HSIZE_M1(hsize1),
        .HWDATA_M1(hwdata1), .HREADY_M1(f_rdy1), .HREADYOUT_M1(f_rdy1), .HRDATA_M1(f_rdata1),
        .HSEL_S(f_sel_s), .HADDR_S(f_addr_s), .HTRANS_S(f_trans_s), .HWRITE_S(f_write_s), .HSIZE_S(f_size_s),
        .HWDATA_S(f_wdata_s), .HREADY_S(f_hready_s), .HREADYOUT_S(1'b1), .HRDATA_S(32'h0)
    );

    // RAM slave model: word-addressed, byte lanes from size/address, preloaded with C0DE0000+addr
    logic [31:0] mem [64];
    logic        init = 1'b1, dp_v = 1'b0, dp_w = 1'b0;
    logic [31:0] dp_a = '0;
    logic [2:0]  dp_sz = '0;
    logic [3:0]  mask;
    always_comb mask = dp_sz == 3'd0 ? 4'b0001 << dp_a[1:0] : dp_sz == 3'd1 ? (dp_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign rdata_s = (dp_v && !dp_w) ? mem[dp_a[7:2]] : '0;
    always @(posedge clk) begin
        if (init)
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 + 32'(i * 4);
        else if (rst)
            dp_v <= 1'b0;
        else if (readyout_s) begin
            if (dp_v && dp_w)
                for (int b = 0; b < 4; b++) if (mask[b]) mem[dp_a[7:2]][8*b +: 8] <= wdata_s[8*b +: 8];
            dp_v  <= sel_s && hready_s && trans_s[1];
            dp_a  <= addr_s;
            dp_w  <= write_s;
            dp_sz <= size_s;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        hsel0 = 0; htrans0 = 0; hsel1 = 0; htrans1 = 0;
    endtask

    task automatic do_reset();
        tick();
        idle_masters();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic drive_both(input logic [31:0] a0, input logic [31:0] a1, input logic wr);
        hsel0 = 1; htrans0 = 2'b10; haddr0 = a0; hwrite0 = wr; hsize0 = 3'd2;
        hsel1 = 1; htrans1 = 2'b10; haddr1 = a1; hwrite1 = wr; hsize1 = 3'd2;
    endtask

    // one M0 transfer; returns wait count and the slave address phase seen in the first data-phase cycle
    task automatic m0_xfer(input logic wr, input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, output logic [31:0] rd, output int waits,
                           output logic [31:0] sa, output logic [2:0] ssz, output logic [1:0] st);
        tick();
        hsel0 = 1; htrans0 = tr; haddr0 = a; hwrite0 = wr; hsize0 = sz;
        tick();
        hsel0 = 0; htrans0 = 0; hwdata0 = wd;
        waits = 0; rd = '0; sa = '0; ssz = '0; st = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin sa = addr_s; ssz = size_s; st = trans_s; end
            if (rdy0) begin rd = rdata0; break; end
            waits++;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        @(posedge clk);
        #1 init = 0;
        @(negedge clk);
        checks++;
        if ({rdy0, rdy1, sel_s, trans_s, hready_s, write_s, size_s} !== 10'b11_0_00_1_0_000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 1100010000", {rdy0, rdy1, sel_s, trans_s, hready_s, write_s, size_s});
        end
        checks++;
        if ({rdata0, rdata1, addr_s, wdata_s} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {rdata0, rdata1, addr_s, wdata_s});
        end
        tick();
        rst = 0;
    endtask

    task automatic test_busy_ignored();
        tick();
        hsel0 = 1; htrans0 = 2'b01; haddr0 = 32'h10;
        tick();
        idle_masters();
        @(negedge clk);
        checks++;
        if ({rdy0, sel_s} !== 2'b10) begin
            errors++;
            $display("FAIL busy_ignored got rdy0/sel_s=%b exp 10", {rdy0, sel_s});
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd, sa;
        logic [2:0]  ssz;
        logic [1:0]  st;
        int          w;
        m0_xfer(1, 2'b10, 32'h10, 3'd2, 32'hDEAD_BEEF, rd, w, sa, ssz, st);
        checks++;
        if (w !== 1) begin errors++; $display("FAIL wr_waits got %0d exp 1", w); end
        checks++;
        if ({sa, st} !== {32'h10, 2'b10}) begin errors++; $display("FAIL wr_issue got %h/%b exp 10/10", sa, st); end
        m0_xfer(0, 2'b11, 32'h10, 3'd2, 32'h0, rd, w, sa, ssz, st);
        checks++;
        if (w !== 1) begin errors++; $display("FAIL rd_waits got %0d exp 1", w); end
        checks++;
        if (st !== 2'b10) begin errors++; $display("FAIL seq_as_nonseq got %b exp 10", st); end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    endtask

    task automatic test_halfword();
        logic [31:0] rd, sa;
        logic [2:0]  ssz;
        logic [1:0]  st;
        int          w;
        m0_xfer(1, 2'b10, 32'h30, 3'd2, 32'hAAAA_5555, rd, w, sa, ssz, st);
        m0_xfer(1, 2'b10, 32'h32, 3'd1, 32'h1234_0000, rd, w, sa, ssz, st);
        checks++;
        if ({sa, ssz} !== {32'h32, 3'b001}) begin errors++; $display("FAIL hw_fwd got %h/%b exp 32/001", sa, ssz); end
        m0_xfer(0, 2'b10, 32'h30, 3'd2, 32'h0, rd, w, sa, ssz, st);
        checks++;
        if (rd !== 32'h1234_5555) begin errors++; $display("FAIL hw_merge got %h exp 12345555", rd); end
    endtask

    task automatic test_rr_tie();
        logic [31:0] glog [$];
        logic [31:0] rd, sa;
        logic [2:0]  ssz;
        logic [1:0]  st;
        int          w, lo0 = 0, lo1 = 0;
        do_reset();
        drive_both(32'h20, 32'h24, 1);
        tick();
        idle_masters();
        hwdata0 = 32'h2020_2020; hwdata1 = 32'h2424_2424;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sel_s) glog.push_back(addr_s);
            if (!rdy0) lo0++;
            if (!rdy1) lo1++;
        end
        checks++;
        if (glog.size() != 2 || glog[0] !== 32'h20 || glog[1] !== 32'h24) begin
            errors++;
            $display("FAIL rr_order got %0d grants first %h exp 20 then 24", glog.size(), glog.size() > 0 ? glog[0] : 32'hx);
        end
        checks++;
        if ({lo0, lo1} !== {32'd1, 32'd2}) begin errors++; $display("FAIL rr_waits got m0=%0d m1=%0d exp 1/2", lo0, lo1); end
        m0_xfer(0, 2'b10, 32'h20, 3'd2, 32'h0, rd, w, sa, ssz, st);
        checks++;
        if (rd !== 32'h2020_2020) begin errors++; $display("FAIL rr_m0_data got %h exp 20202020", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] glog [$];
        int          n_iss [2] = '{0, 0};
        int          n_done [2] = '{0, 0};
        logic        dpv [2] = '{0, 0};
        logic [31:0] dpa [2];
        int          first = -1, last = -1, bad = 0;
        logic [31:0] ex;
        do_reset();
        for (int c = 0; c < 60 && (n_done[0] < 8 || n_done[1] < 8); c++) begin
            if (c > 0) tick();
            hsel0 = n_iss[0] < 8; htrans0 = n_iss[0] < 8 ? 2'b10 : 2'b00; haddr0 = 32'h80 + 32'(4 * n_iss[0]);
            hsel1 = n_iss[1] < 8; htrans1 = n_iss[1] < 8 ? 2'b10 : 2'b00; haddr1 = 32'hC0 + 32'(4 * n_iss[1]);
            hwrite0 = 0; hwrite1 = 0; hsize0 = 3'd2; hsize1 = 3'd2;
            @(negedge clk);
            if (sel_s) begin glog.push_back(addr_s); if (first < 0) first = c; last = c; end
            if (rdy0) begin
                if (dpv[0]) begin
                    checks++;
                    if (rdata0 !== 32'hC0DE_0000 + dpa[0]) begin errors++; $display("FAIL stream_m0 got %h exp %h", rdata0, 32'hC0DE_0000 + dpa[0]); end
                    n_done[0]++;
                end
                dpv[0] = hsel0; dpa[0] = haddr0;
                if (hsel0) n_iss[0]++;
            end
            if (rdy1) begin
                if (dpv[1]) begin
                    checks++;
                    if (rdata1 !== 32'hC0DE_0000 + dpa[1]) begin errors++; $display("FAIL stream_m1 got %h exp %h", rdata1, 32'hC0DE_0000 + dpa[1]); end
                    n_done[1]++;
                end
                dpv[1] = hsel1; dpa[1] = haddr1;
                if (hsel1) n_iss[1]++;
            end
        end
        idle_masters();
        checks++;
        if (n_done[0] != 8 || n_done[1] != 8) begin errors++; $display("FAIL stream_done got %0d/%0d exp 8/8", n_done[0], n_done[1]); end
        checks++;
        if (glog.size() != 16 || last - first + 1 != 16) begin
            errors++;
            $display("FAIL stream_gapless got %0d grants over %0d cycles exp 16/16", glog.size(), last - first + 1);
        end
        for (int k = 0; k < glog.size(); k++) begin
            ex = (k % 2 == 0) ? 32'h80 + 32'(4 * (k / 2)) : 32'hC0 + 32'(4 * (k / 2));
            if (glog[k] !== ex) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stream_alternate got %0d misordered grants exp 0", bad); end
    endtask

    task automatic test_stall();
        int lo0 = 0, badc = 0;
        tick();
        tick();
        hsel0 = 1; htrans0 = 2'b10; haddr0 = 32'h10; hwrite0 = 0; hsize0 = 3'd2;
        tick();
        hsel0 = 0; htrans0 = 0;
        hsel1 = 1; htrans1 = 2'b10; haddr1 = 32'h24; hwrite1 = 0; hsize1 = 3'd2;
        @(negedge clk);
        checks++;
        if ({sel_s, addr_s} !== {1'b1, 32'h10}) begin errors++; $display("FAIL stall_issue_m0 got %b/%h exp 1/10", sel_s, addr_s); end
        tick();
        idle_masters();
        readyout_s = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!rdy0) lo0++;
            if (hready_s !== 1'b0 || sel_s !== 1'b0 || rdy1 !== 1'b0) badc++;
            tick();
        end
        readyout_s = 1;
        checks++;
        if (lo0 != 3 || badc != 0) begin errors++; $display("FAIL stall_hold got m0_low=%0d bad=%0d exp 3/0", lo0, badc); end
        @(negedge clk);
        checks++;
        if ({rdy0, hready_s, sel_s, addr_s} !== {3'b111, 32'h24}) begin
            errors++;
            $display("FAIL stall_release got rdy0/hready/sel=%b addr=%h exp 111/24", {rdy0, hready_s, sel_s}, addr_s);
        end
        checks++;
        if (rdata0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_rdata got %h exp deadbeef", rdata0); end
        tick();
        @(negedge clk);
        checks++;
        if ({rdy1, rdata1} !== {1'b1, 32'h2424_2424}) begin errors++; $display("FAIL stall_m1 got %b/%h exp 1/24242424", rdy1, rdata1); end
    endtask

    task automatic test_fixed_priority();
        logic [31:0] rd, sa;
        logic [2:0]  ssz;
        logic [1:0]  st;
        int          w;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            m0_xfer(1, 2'b10, 32'h40, 3'd2, 32'h4040_0000 + 32'(r), rd, w, sa, ssz, st);
            tick();
            drive_both(32'h44, 32'h48, 1);
            tick();
            idle_masters();
            @(negedge clk);
            checks++;
            if ({f_sel_s, f_addr_s} !== {1'b1, 32'h44}) begin errors++; $display("FAIL fp_tie%0d got %b/%h exp 1/44", r, f_sel_s, f_addr_s); end
            checks++;
            if ({sel_s, addr_s} !== {1'b1, 32'h48}) begin errors++; $display("FAIL rr_tie%0d got %b/%h exp 1/48", r, sel_s, addr_s); end
            @(negedge clk);
            checks++;
            if ({f_addr_s, addr_s} !== {32'h48, 32'h44}) begin errors++; $display("FAIL tie%0d_second got fp=%h rr=%h exp 48/44", r, f_addr_s, addr_s); end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        drive_both(32'h50, 32'h54, 0);
        tick();
        idle_masters();
        #2 rst = 1;
        #1;
        checks++;
        if ({rdy0, rdy1, sel_s, trans_s, hready_s, f_sel_s, f_rdy1} !== 8'b11_0_00_1_0_1) begin
            errors++;
            $display("FAIL reset_mid got %b exp 11000101", {rdy0, rdy1, sel_s, trans_s, hready_s, f_sel_s, f_rdy1});
        end
        checks++;
        if ({addr_s, rdata0, rdata1} !== 96'h0) begin errors++; $display("FAIL reset_mid_data got %h exp 0", {addr_s, rdata0, rdata1}); end
        tick();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sel_s || f_sel_s) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL reset_no_reissue got %0d issue cycles exp 0", n); end
    endtask

    initial begin
        test_reset();
        test_busy_ignored();
        test_word_rw();
        test_halfword();
        test_rr_tie();
        test_back_to_back();
        test_stall();
        test_fixed_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
